vga_scanout: RTL and testbench

Raster timing generator and VGA output stage for the 640x480@60 display path. Generates the (x, y) pixel coordinates consumed by the registered pixel-source blocks (image/colour generators). It accepts their RGB answer a fixed number of cycles later, aligns sync and blank to that latency, and drives the board VGA DAC pins. Sits between the pixel-source mux and the top-level VGA pins; `clk` is the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_scanout.sv | 174 +++++++++++++++++
 tb/tb_vga_scanout.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scanout slice.
//   - 640x480@60 timing defaults
//   - axis_state_t: per-axis raster region decoded from a counter
//   - ctl_t: control word {hs, vs, active} carried alongside pixel latency
//   - pattern bar width for the optional test pattern (VGA_TESTPATTERN_EN)
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned CNT_MAX_SPAN = 1 << CNT_W;

    localparam int unsigned BAR_WIDTH    = 80;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } ctl_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset, counter returns to 0
//   tick   in   advance enable (1 for horizontal, h wrap for vertical)
//   count  out  current position 0..TOTAL-1
//   state  out  region of count: ACTIVE, FRONT, SYNC, BACK in that order
//   wrap   out  high on the tick that takes count from TOTAL-1 back to 0
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BACK   = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    output logic [9:0]            count,
    output vga_pkg::axis_state_t  state,
    output logic                  wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BACK;

    if (TOTAL > vga_pkg::CNT_MAX_SPAN || ACTIVE == 0 || SYNC == 0) begin : g_bad_timing
        $error("vga_axis_counter: axis total must be 1..1024 with nonzero ACTIVE and SYNC");
    end

    localparam logic [9:0] LAST       = 10'(TOTAL - 1);
    localparam logic [9:0] FP_START   = 10'(ACTIVE);
    localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
    localparam logic [9:0] BACK_START = 10'(ACTIVE + FP + SYNC);

    logic [9:0] count_q;
    logic [9:0] count_d;
    logic       at_last;

    assign at_last = (count_q == LAST);
    assign wrap    = tick && at_last;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = at_last ? '0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        if (count_q < FP_START) begin
            state = vga_pkg::ACTIVE;
        end else if (count_q < SYNC_START) begin
            state = vga_pkg::FRONT;
        end else if (count_q < BACK_START) begin
            state = vga_pkg::SYNC;
        end else begin
            state = vga_pkg::BACK;
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and registered VGA output stage.
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   x, y                coordinate issued to the pixel source (blanking included)
//   red, green, blue    pixel-source colour for the coordinate issued PIX_LAT clocks earlier
//   frame_start         high while x=0, y=0 is presented
//   VGA_R/G/B           DAC colour, forced to 0 outside the active area
//   VGA_HS, VGA_VS      active-low sync
//   VGA_BLANK_N         low outside the active area
//   VGA_SYNC_N          tied low
// Optional build macro VGA_TESTPATTERN_EN: ignore red/green/blue and emit eight
// 80-pixel vertical bars, colour = bar index bits {R,G,B} expanded to 0xFF.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
        $error("vga_scanout: PIX_LAT must be in 1..4");
    end

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    axis_state_t hstate;
    axis_state_t vstate;
    logic        h_wrap;
    logic        v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BACK   (H_BP)
    ) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (1'b1),
        .count (hcnt),
        .state (hstate),
        .wrap  (h_wrap)
    );

    // Vertical advances on the same edge that wraps the horizontal counter.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BACK   (V_BP)
    ) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (h_wrap),
        .count (vcnt),
        .state (vstate),
        .wrap  (v_wrap_unused)
    );

    assign x           = hcnt;
    assign y           = vcnt;
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    assign VGA_SYNC_N  = 1'b0;

    ctl_t ctl_now;
    ctl_t ctl_q [PIX_LAT];
    ctl_t ctl_out;

    assign ctl_now.hs     = (hstate == SYNC);
    assign ctl_now.vs     = (vstate == SYNC);
    assign ctl_now.active = (hstate == ACTIVE) && (vstate == ACTIVE);
    assign ctl_out        = ctl_q[PIX_LAT-1];

    // Cleared pipeline means a reset mid-frame cannot replay a stale sync pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIX_LAT; i++) begin
                ctl_q[i] <= '0;
            end
        end else begin
            ctl_q[0] <= ctl_now;
            for (int unsigned i = 1; i < PIX_LAT; i++) begin
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    logic [7:0] src_r;
    logic [7:0] src_g;
    logic [7:0] src_b;

`ifdef VGA_TESTPATTERN_EN
    logic [23:0] rgb_in_unused;
    logic [2:0]  bar_now;
    logic [2:0]  bar_q [PIX_LAT];

    assign rgb_in_unused = {red, green, blue};
    // Beyond x=639 the index wraps, but active masks those pixels.
    assign bar_now = 3'(hcnt / 10'(BAR_WIDTH));

    // Bar index rides the same delay as the control word so pin timing is unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIX_LAT; i++) begin
                bar_q[i] <= '0;
            end
        end else begin
            bar_q[0] <= bar_now;
            for (int unsigned i = 1; i < PIX_LAT; i++) begin
                bar_q[i] <= bar_q[i-1];
            end
        end
    end

    assign src_r = {8{bar_q[PIX_LAT-1][2]}};
    assign src_g = {8{bar_q[PIX_LAT-1][1]}};
    assign src_b = {8{bar_q[PIX_LAT-1][0]}};
`else
    assign src_r = red;
    assign src_g = green;
    assign src_b = blue;
`endif

    logic [7:0] r_q, g_q, b_q;
    logic       hs_n_q, vs_n_q, blank_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            r_q       <= ctl_out.active ? src_r : '0;
            g_q       <= ctl_out.active ? src_g : '0;
            b_q       <= ctl_out.active ? src_b : '0;
            hs_n_q    <= ~ctl_out.hs;
            vs_n_q    <= ~ctl_out.vs;
            blank_n_q <= ctl_out.active;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_n_q;
    assign VGA_VS      = vs_n_q;
    assign VGA_BLANK_N = blank_n_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout.
//   dut   : default 640x480 timing, PIX_LAT=1, checked against a hand-computed vector table
//   dut_s : shrunken raster (16x10 totals), PIX_LAT=3, checked cycle by cycle over
//           several frames and through a reset asserted inside vsync
module tb_vga_scanout;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    // ---------------- default-timing instance ----------------
    logic [9:0] x1, y1;
    logic       fs1;
    logic [7:0] red1 = '0, green1 = '0, blue1 = '0;
    logic [7:0] r1, g1, b1;
    logic       hs1, vs1, bl1, sn1;

    vga_scanout #(.PIX_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1),
        .red(red1), .green(green1), .blue(blue1), .frame_start(fs1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1)
    );

    // ---------------- small-timing instance ----------------
    logic [9:0] x2, y2;
    logic       fs2;
    logic [7:0] red2, green2, blue2;
    logic [7:0] r2, g2, b2;
    logic       hs2, vs2, bl2, sn2;

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIX_LAT(3)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .x(x2), .y(y2),
        .red(red2), .green(green2), .blue(blue2), .frame_start(fs2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2),
        .VGA_BLANK_N(bl2), .VGA_SYNC_N(sn2)
    );

    // ---------------- pixel-source models ----------------
    logic [23:0] sp [3];
    initial for (int i = 0; i < 3; i++) sp[i] = '0;

`ifdef VGA_TESTPATTERN_EN
    assign red2 = 8'h55;
    assign green2 = 8'h55;
    assign blue2 = 8'h55;
    initial begin
        red1 = 8'h55; green1 = 8'h55; blue1 = 8'h55;
    end
`else
    // red=x, green=y, blue=x+y; one stage for dut, three for dut_s
    always @(posedge clk) begin
        red1   <= x1[7:0];
        green1 <= y1[7:0];
        blue1  <= x1[7:0] + y1[7:0];
        sp[0]  <= {x2[7:0], y2[7:0], 8'(x2[7:0] + y2[7:0])};
        sp[1]  <= sp[0];
        sp[2]  <= sp[1];
    end
    assign red2   = sp[2][23:16];
    assign green2 = sp[2][15:8];
    assign blue2  = sp[2][7:0];
`endif

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected small-instance outputs k cycles after reset release (PIX_LAT+1 = 4).
    function automatic logic [63:0] exp_small(input int k);
        int h = 0, v = 0;
        logic act = 1'b0, hs = 1'b1, vs = 1'b1, fs;
        logic [9:0] xx, yy;
        logic [23:0] rgb = '0;
        xx = 10'(k % 16);
        yy = 10'((k / 16) % 10);
        fs = (xx == 0) && (yy == 0);
        if (k >= 4) begin
            h   = (k - 4) % 16;
            v   = ((k - 4) / 16) % 10;
            act = (h < 8) && (v < 4);
            hs  = !(h >= 10 && h < 13);
            vs  = !(v >= 6 && v < 8);
        end
`ifndef VGA_TESTPATTERN_EN
        if (act) rgb = {8'(h), 8'(v), 8'(h + v)};
`endif
        return {16'd0, fs, xx, yy, hs, vs, act, rgb};
    endfunction

    function automatic logic [63:0] act_small();
        return {16'd0, fs2, x2, y2, hs2, vs2, bl2, r2, g2, b2};
    endfunction

    typedef struct {
        int          k;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [7:0]  r;
        logic [23:0] tp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    int hs_fall0, hs_fall1, hs_len0;
    int vs_fall0, vs_fall1, vs_len0;
    int fs_rise0, fs_rise1;
    logic p_hs1, p_vs2, p_fs2;
    int ti;
    bit found;

    initial begin
        // k: cycles after release; x,y,fs issued now; pins show pixel k-2
        tbl = '{
            '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{1,   10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{2,   10'd2,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   24'h000000},
            '{3,   10'd3,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1,   24'h000000},
            '{82,  10'd82,  10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd80,  24'h0000FF},
            '{202, 10'd202, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd200, 24'h00FF00},
            '{562, 10'd562, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd48,  24'hFFFFFF},
            '{641, 10'd641, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd127, 24'hFFFFFF},
            '{642, 10'd642, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{657, 10'd657, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{658, 10'd658, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{753, 10'd753, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{754, 10'd754, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{799, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{800, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   24'h000000},
            '{802, 10'd2,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   24'h000000},
            '{803, 10'd3,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1,   24'h000000}
        };

        // ---- reset held ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst big ctl", {x1, y1, fs1, hs1, vs1, bl1, sn1}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        check("rst big rgb", {r1, g1, b1}, 24'h0);
        check("rst small", act_small(), exp_small(0));
        check("rst small sync_n", sn2, 1'b0);

        // ---- release and free run ----
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ti = 0;
        hs_fall0 = -1; hs_fall1 = -1; hs_len0 = -1;
        vs_fall0 = -1; vs_fall1 = -1; vs_len0 = -1;
        fs_rise0 = -1; fs_rise1 = -1;
        p_hs1 = 1'b1; p_vs2 = 1'b1; p_fs2 = 1'b0;
        for (int k = 0; k < 1700; k++) begin
            if (ti < NVEC && tbl[ti].k == k) begin
                check($sformatf("vec%0d ctl", ti), {x1, y1, fs1, hs1, vs1, bl1, sn1},
                      {tbl[ti].x, tbl[ti].y, tbl[ti].fs, tbl[ti].hs, tbl[ti].vs, tbl[ti].bl, 1'b0});
`ifdef VGA_TESTPATTERN_EN
                check($sformatf("vec%0d rgb", ti), {r1, g1, b1}, tbl[ti].tp);
`else
                check($sformatf("vec%0d red", ti), r1, tbl[ti].r);
`endif
                ti++;
            end
            check($sformatf("small k=%0d", k), act_small(), exp_small(k));

            if (p_hs1 && !hs1) begin
                if (hs_fall0 < 0) hs_fall0 = k; else if (hs_fall1 < 0) hs_fall1 = k;
            end
            if (!p_hs1 && hs1 && hs_len0 < 0) hs_len0 = k - hs_fall0;
            if (p_vs2 && !vs2) begin
                if (vs_fall0 < 0) vs_fall0 = k; else if (vs_fall1 < 0) vs_fall1 = k;
            end
            if (!p_vs2 && vs2 && vs_len0 < 0) vs_len0 = k - vs_fall0;
            if (!p_fs2 && fs2) begin
                if (fs_rise0 < 0) fs_rise0 = k; else if (fs_rise1 < 0) fs_rise1 = k;
            end
            p_hs1 = hs1; p_vs2 = vs2; p_fs2 = fs2;
            @(negedge clk);
            #1;
        end
        check("table consumed", ti, NVEC);
        check("hsync start", hs_fall0, 658);
        check("hsync width", hs_len0, 96);
        check("line period", hs_fall1 - hs_fall0, 800);
        check("small vsync start", vs_fall0, 100);
        check("small vsync width", vs_len0, 32);
        check("small vsync period", vs_fall1 - vs_fall0, 160);
        check("small frame_start first", fs_rise0, 0);
        check("small frame_start period", fs_rise1 - fs_rise0, 160);

        // ---- reset asserted inside vsync (small instance at x=12, y=7) ----
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (x2 == 10'd12 && y2 == 10'd7) found = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("reach x12 y7", found, 1'b1);
        check("vsync low before reset", vs2, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        check("async rst small", {fs2, x2, y2, hs2, vs2, bl2}, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
        check("async rst small rgb", {r2, g2, b2}, 24'h0);
        check("async rst big", {fs1, x1, y1, hs1, vs1, bl1}, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vs_fall0 = -1;
        p_vs2 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            check($sformatf("post-rst small k=%0d", k), act_small(), exp_small(k));
            if (p_vs2 && !vs2 && vs_fall0 < 0) vs_fall0 = k;
            p_vs2 = vs2;
            @(negedge clk);
            #1;
        end
        check("post-rst vsync start", vs_fall0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
